eu_sequencer: RTL and testbench

- Sequential front/back end for the execution unit (logic and arithmetic sub-units).
- Collects operand A, then operand B, from the shared data bus over successive cycles, and holds op_select plus both operands stable while the EU evaluates.
- Registers the EU result and presents it downstream with a valid/ack handshake.
- Sits between the control unit / register-file bus and the combinational EU sub-units.

---
 rtl/eu_sequencer.sv | 97 +++++++++
 tb/tb_eu_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_sequencer.sv
// Operand collection and result hand-off around the combinational execution unit.
// Gathers A then B from the shared bus, holds them for one EXEC cycle, then presents the result.
module eu_sequencer #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           op_in,
    input  logic                 abort,
    input  logic [BUS_WIDTH-1:0] bus_in,
    input  logic                 bus_in_valid,
    input  logic [BUS_WIDTH-1:0] eu_result,
    output logic [3:0]           op_select,
    output logic [BUS_WIDTH-1:0] eu_a,
    output logic [BUS_WIDTH-1:0] eu_b,
    output logic [BUS_WIDTH-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic                 zero_flag,
    output logic                 busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StExec,
        StHold
    } state_e;

    // NOT is the only unary operation; it never fetches B.
    localparam logic [3:0] OpNot = 4'b1011;

    state_e state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            op_select    <= 4'b0000;
            eu_a         <= '0;
            eu_b         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            zero_flag    <= 1'b0;
        end else if (abort && state != StIdle) begin
            // Abort wins over every capture, including the EXEC result load.
            state        <= StIdle;
            result_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start && !abort) begin
                        op_select <= op_in;
                        state     <= StLoadA;
                    end
                end
                StLoadA: begin
                    if (bus_in_valid) begin
                        eu_a <= bus_in;
                        if (op_select == OpNot) begin
                            eu_b  <= '0;
                            state <= StExec;
                        end else begin
                            state <= StLoadB;
                        end
                    end
                end
                StLoadB: begin
                    if (bus_in_valid) begin
                        eu_b  <= bus_in;
                        state <= StExec;
                    end
                end
                StExec: begin
                    result       <= eu_result;
                    zero_flag    <= (eu_result == '0);
                    result_valid <= 1'b1;
                    state        <= StHold;
                end
                StHold: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    state        <= StIdle;
                end
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_eu_sequencer.sv
// Directed bench for eu_sequencer with a small reference EU driving eu_result.
module tb_eu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op_in;
    logic       abort;
    logic [7:0] bus_in;
    logic       bus_in_valid;
    logic [7:0] eu_result;
    logic [3:0] op_select;
    logic [7:0] eu_a;
    logic [7:0] eu_b;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ack;
    logic       zero_flag;
    logic       busy;

    int errors = 0;
    int checks = 0;

    eu_sequencer #(.BUS_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op_in        (op_in),
        .abort        (abort),
        .bus_in       (bus_in),
        .bus_in_valid (bus_in_valid),
        .eu_result    (eu_result),
        .op_select    (op_select),
        .eu_a         (eu_a),
        .eu_b         (eu_b),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .zero_flag    (zero_flag),
        .busy         (busy)
    );

    // Reference EU: AND, OR, XOR, NOT, otherwise ADD.
    always_comb begin
        case (op_select)
            4'b1000: eu_result = eu_a & eu_b;
            4'b1001: eu_result = eu_a | eu_b;
            4'b1010: eu_result = eu_a ^ eu_b;
            4'b1011: eu_result = ~eu_a;
            default: eu_result = eu_a + eu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op_in = 4'h0; abort = 1'b0;
        bus_in = 8'h00; bus_in_valid = 1'b0; result_ack = 1'b0;
        #2;
        checks++;
        if ({op_select, eu_a, eu_b, result, result_valid, zero_flag, busy} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%h/%h/%b/%b/%b want all zero",
                     op_select, eu_a, eu_b, result, result_valid, zero_flag, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        op_in = 4'b1000; start = 1'b1; tick();
        start = 1'b0; bus_in = 8'h3C; bus_in_valid = 1'b1; tick();
        bus_in_valid = 1'b0;
        checks++;
        if (eu_a !== 8'h3C || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_load_a: got eu_a=%h busy=%b want 3c 1", eu_a, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({op_select, eu_a, eu_b, result, result_valid, zero_flag, busy} !== 31'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h/%h/%h/%h/%b/%b/%b want all zero",
                     op_select, eu_a, eu_b, result, result_valid, zero_flag, busy);
        end
        rst_n = 1'b1;
        bus_in = 8'h11; bus_in_valid = 1'b1;
        tick(); tick();
        bus_in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || eu_b !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_after: got busy=%b rv=%b eu_b=%h want 0 0 00",
                     busy, result_valid, eu_b);
        end
    endtask

    task automatic test_and();
        op_in = 4'b1000; start = 1'b1; tick();            // cycle 1: LOAD_A
        start = 1'b0; bus_in = 8'hF0; bus_in_valid = 1'b1; tick();  // cycle 2: LOAD_B
        bus_in = 8'h3C; tick();                            // cycle 3: EXEC
        bus_in_valid = 1'b0;
        checks++;
        if ({op_select, eu_a, eu_b} !== {4'b1000, 8'hF0, 8'h3C}) begin
            errors++;
            $display("FAIL and_operands: got %b %h %h want 1000 f0 3c", op_select, eu_a, eu_b);
        end
        checks++;
        if (result_valid !== 1'b0) begin
            errors++; $display("FAIL and_valid_c3: got %b want 0", result_valid);
        end
        tick();                                            // cycle 4: HOLD
        checks++;
        if ({result, result_valid, zero_flag} !== {8'h30, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL and_result: got %h rv=%b z=%b want 30 1 0",
                     result, result_valid, zero_flag);
        end
        result_ack = 1'b1; tick(); result_ack = 1'b0;
        checks++;
        if ({busy, result_valid, result} !== {1'b0, 1'b0, 8'h30}) begin
            errors++;
            $display("FAIL and_ack: got busy=%b rv=%b res=%h want 0 0 30",
                     busy, result_valid, result);
        end
    endtask

    task automatic test_not();
        op_in = 4'b1011; start = 1'b1; tick();            // cycle 1: LOAD_A
        start = 1'b0; bus_in = 8'hFF; bus_in_valid = 1'b1; tick();  // cycle 2: EXEC
        bus_in = 8'h77;
        checks++;
        if ({eu_a, eu_b, result_valid} !== {8'hFF, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL not_operands: got a=%h b=%h rv=%b want ff 00 0",
                     eu_a, eu_b, result_valid);
        end
        tick();                                            // cycle 3: HOLD
        bus_in_valid = 1'b0;
        checks++;
        if ({result, result_valid, zero_flag, eu_b} !== {8'h00, 1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL not_result: got %h rv=%b z=%b b=%h want 00 1 1 00",
                     result, result_valid, zero_flag, eu_b);
        end
        result_ack = 1'b1; tick(); result_ack = 1'b0;
    endtask

    task automatic test_stall();
        op_in = 4'b1010; start = 1'b1; tick();
        start = 1'b0; bus_in = 8'h99; bus_in_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1 || eu_a !== 8'hFF) begin
            errors++; $display("FAIL stall_a: got busy=%b a=%h want 1 ff", busy, eu_a);
        end
        bus_in = 8'hAA; bus_in_valid = 1'b1; tick();
        bus_in = 8'h66; bus_in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (eu_a !== 8'hAA || eu_b !== 8'h00 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_b: got a=%h b=%h rv=%b want aa 00 0", eu_a, eu_b, result_valid);
        end
        bus_in = 8'h55; bus_in_valid = 1'b1; tick();
        bus_in_valid = 1'b0; tick();
        checks++;
        if ({result, zero_flag, result_valid} !== {8'hFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall_result: got %h z=%b rv=%b want ff 0 1",
                     result, zero_flag, result_valid);
        end
        bus_in = 8'h12; bus_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({result, zero_flag, op_select, eu_a, eu_b, result_valid}
                !== {8'hFF, 1'b0, 4'b1010, 8'hAA, 8'h55, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h %b %b %h %h %b want ff 0 1010 aa 55 1",
                         i, result, zero_flag, op_select, eu_a, eu_b, result_valid);
            end
        end
        bus_in_valid = 1'b0;
        result_ack = 1'b1; tick(); result_ack = 1'b0;
    endtask

    task automatic test_abort();
        op_in = 4'b1000; start = 1'b1; tick();
        start = 1'b0; bus_in = 8'h0F; bus_in_valid = 1'b1; tick();   // now LOAD_B
        bus_in = 8'h77; abort = 1'b1; tick();
        abort = 1'b0; bus_in_valid = 1'b0;
        checks++;
        if ({busy, result_valid, eu_b, result} !== {1'b0, 1'b0, 8'h55, 8'hFF}) begin
            errors++;
            $display("FAIL abort_loadb: got busy=%b rv=%b b=%h res=%h want 0 0 55 ff",
                     busy, result_valid, eu_b, result);
        end
        repeat (3) tick();
        checks++;
        if (result_valid !== 1'b0 || result !== 8'hFF) begin
            errors++;
            $display("FAIL abort_loadb_later: got rv=%b res=%h want 0 ff", result_valid, result);
        end
        op_in = 4'b1001; start = 1'b1; tick();
        start = 1'b0; bus_in = 8'h01; bus_in_valid = 1'b1; tick();
        bus_in = 8'h02; tick();                                       // now EXEC
        bus_in_valid = 1'b0; abort = 1'b1; tick();
        abort = 1'b0;
        checks++;
        if ({busy, result_valid, result, zero_flag, eu_b} !== {1'b0, 1'b0, 8'hFF, 1'b0, 8'h02})
        begin
            errors++;
            $display("FAIL abort_exec: got busy=%b rv=%b res=%h z=%b b=%h want 0 0 ff 0 02",
                     busy, result_valid, result, zero_flag, eu_b);
        end
    endtask

    task automatic test_handshake();
        op_in = 4'b0000; start = 1'b1; tick();                        // LOAD_A
        op_in = 4'b1011; bus_in_valid = 1'b0; tick();                 // start during LOAD_A
        start = 1'b0;
        checks++;
        if (op_select !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hs_start_loada: got op=%b busy=%b want 0000 1", op_select, busy);
        end
        bus_in = 8'h10; bus_in_valid = 1'b1; tick();
        bus_in = 8'h20; tick();                                       // EXEC
        bus_in_valid = 1'b0; start = 1'b1; tick();                    // start during EXEC
        checks++;
        if ({op_select, result, result_valid} !== {4'b0000, 8'h30, 1'b1}) begin
            errors++;
            $display("FAIL hs_start_exec: got op=%b res=%h rv=%b want 0000 30 1",
                     op_select, result, result_valid);
        end
        result_ack = 1'b1; tick();                                    // start+ack in HOLD
        start = 1'b0; result_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL hs_start_ack: got busy=%b rv=%b want 0 0", busy, result_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || op_select !== 4'b0000) begin
            errors++;
            $display("FAIL hs_no_queue: got busy=%b op=%b want 0 0000", busy, op_select);
        end
        result_ack = 1'b1; tick();
        checks++;
        if ({busy, result_valid, result} !== {1'b0, 1'b0, 8'h30}) begin
            errors++;
            $display("FAIL hs_ack_idle: got busy=%b rv=%b res=%h want 0 0 30",
                     busy, result_valid, result);
        end
        op_in = 4'b1000; start = 1'b1; tick();
        start = 1'b0; tick();                                         // ack held in LOAD_A
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL hs_ack_loada: got busy=%b rv=%b want 1 0", busy, result_valid);
        end
        result_ack = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        abort = 1'b1; start = 1'b1; op_in = 4'b1010; tick();          // abort blocks start
        abort = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || op_select !== 4'b1000) begin
            errors++;
            $display("FAIL hs_abort_idle: got busy=%b op=%b want 0 1000", busy, op_select);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_and();
        test_not();
        test_stall();
        test_abort();
        test_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
